// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg: response type and sizing helpers shared by soc_mem_ctrl and its delay line.
package soc_mem_pkg;
  localparam int MEM_LAT_MAX = 8;
  localparam int MEM_W_MAX = 128;
  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [MEM_W_MAX-1:0] rdata;
  } mem_rsp_t;
  function automatic int mem_bytes_log2(input int w);
    return $clog2(w / 8);
  endfunction
endpackage

// File: rtl/soc_mem_delay.sv
// soc_mem_delay: LATENCY-stage response shift register; reset clears every stage so idle outputs read 0.
module soc_mem_delay
  import soc_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  mem_rsp_t rsp_d,
  output mem_rsp_t rsp_q
);
  mem_rsp_t stg [LATENCY];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
    else begin
      stg[0] <= rsp_d;
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
  assign rsp_q = stg[LATENCY-1];
endmodule

// File: rtl/soc_mem_ctrl.sv
// soc_mem_ctrl: single-port on-chip memory with fixed-latency in-order responses.
// Define SOC_MEM_CTRL_ERR_EN to flag out-of-range accesses; otherwise the index wraps.
module soc_mem_ctrl
  import soc_mem_pkg::*;
#(
  parameter int          MEM_W     = 32,
  parameter int          MEM_SIZE  = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mem_req_i,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic               mem_err_o,
  output logic [MEM_W-1:0]   mem_rdata_o
);
  localparam int BL    = mem_bytes_log2(MEM_W);
  localparam int DEPTH = MEM_SIZE / (MEM_W / 8);
  localparam int IW    = $clog2(DEPTH);
  logic [MEM_W-1:0] mem [DEPTH];
  logic [31:0]      off;
  logic [IW-1:0]    idx;
  logic             oor;
  mem_rsp_t         rsp_d, rsp_q;
  assign off = mem_addr_i - BASE_ADDR;
  assign idx = IW'(off >> BL);
`ifdef SOC_MEM_CTRL_ERR_EN
  // Addresses below BASE_ADDR wrap to a huge offset and are caught here too.
  assign oor = off >= 32'(MEM_SIZE);
`else
  assign oor = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (mem_req_i && mem_we_i && !oor)
      for (int k = 0; k < MEM_W / 8; k++)
        if (mem_be_i[k]) mem[idx][8*k +: 8] <= mem_wdata_i[8*k +: 8];
  assign rsp_d = '{
    valid: mem_req_i,
    err:   mem_req_i && oor,
    rdata: (mem_req_i && !mem_we_i && !oor) ? MEM_W_MAX'(mem[idx]) : '0
  };
  soc_mem_delay #(.LATENCY(LATENCY)) u_delay (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rsp_d (rsp_d),
    .rsp_q (rsp_q)
  );
  assign mem_rvalid_o = rsp_q.valid;
  assign mem_err_o    = rsp_q.err;
  assign mem_rdata_o  = MEM_W'(rsp_q.rdata);
endmodule

// File: tb/tb_soc_mem_ctrl.sv
// tb_soc_mem_ctrl: directed scoreboard bench over three configurations of soc_mem_ctrl.
module tb_soc_mem_ctrl;
  logic clk = 1'b0, rst_ni = 1'b1;
  always #5 clk = ~clk;
  typedef struct {
    int          due;
    logic        err;
    logic [63:0] data;
  } exp_t;
  exp_t q[3][$];
  int cyc = 0, total = 0, bad = 0;
  int lat[3] = '{4, 3, 1};
  logic        req [3];
  logic        we  [3];
  logic [31:0] addr[3];
  logic [7:0]  be  [3];
  logic [63:0] wd  [3];
  logic        rv_a, rv_b, rv_c, er_a, er_b, er_c;
  logic [31:0] rd_a, rd_b;
  logic [63:0] rd_c;
  soc_mem_ctrl #(.MEM_W(32), .MEM_SIZE(65536), .BASE_ADDR(32'h0), .LATENCY(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(req[0]), .mem_addr_i(addr[0]), .mem_we_i(we[0]),
    .mem_be_i(be[0][3:0]), .mem_wdata_i(wd[0][31:0]),
    .mem_rvalid_o(rv_a), .mem_err_o(er_a), .mem_rdata_o(rd_a)
  );
  soc_mem_ctrl #(.MEM_W(32), .MEM_SIZE(65536), .BASE_ADDR(32'h0), .LATENCY(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(req[1]), .mem_addr_i(addr[1]), .mem_we_i(we[1]),
    .mem_be_i(be[1][3:0]), .mem_wdata_i(wd[1][31:0]),
    .mem_rvalid_o(rv_b), .mem_err_o(er_b), .mem_rdata_o(rd_b)
  );
  soc_mem_ctrl #(.MEM_W(64), .MEM_SIZE(65536), .BASE_ADDR(32'h0), .LATENCY(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_ni), .mem_req_i(req[2]), .mem_addr_i(addr[2]), .mem_we_i(we[2]),
    .mem_be_i(be[2]), .mem_wdata_i(wd[2]),
    .mem_rvalid_o(rv_c), .mem_err_o(er_c), .mem_rdata_o(rd_c)
  );
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int i, input logic v, input logic e, input logic [63:0] d);
    exp_t x;
    while (q[i].size() != 0 && q[i][0].due < cyc) begin
      chk($sformatf("missing_rsp%0d", i), 64'(cyc), 64'(q[i][0].due));
      x = q[i].pop_front();
    end
    if (v) begin
      if (q[i].size() == 0) chk($sformatf("spurious_rsp%0d", i), 64'(v), 64'(0));
      else begin
        x = q[i].pop_front();
        chk($sformatf("latency%0d", i), 64'(cyc), 64'(x.due));
        chk($sformatf("err%0d", i), 64'(e), 64'(x.err));
        chk($sformatf("rdata%0d", i), d, x.data);
      end
    end else begin
      chk($sformatf("idle_err%0d", i), 64'(e), 64'(0));
      chk($sformatf("idle_rdata%0d", i), d, 64'(0));
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv_a, er_a, 64'(rd_a));
    mon(1, rv_b, er_b, 64'(rd_b));
    mon(2, rv_c, er_c, rd_c);
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [7:0] b,
                       input logic [63:0] wdat, input logic e, input logic [63:0] exp);
    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wd[i] = wdat;
    q[i].push_back('{due: cyc + lat[i], err: e, data: exp});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wd[i] = '0;
    end
    #1 rst_ni = 1'b0;
    repeat (2) step();
    chk("reset_rvalid_a", 64'(rv_a), 64'(0));
    chk("reset_rvalid_b", 64'(rv_b), 64'(0));
    chk("reset_rvalid_c", 64'(rv_c), 64'(0));
    rst_ni = 1'b1;
    step();
    issue(0, 1, 32'h100, 8'hF, 64'hDEADBEEF, 0, 0); step();
    issue(0, 1, 32'h100, 8'h1, 64'h000000AA, 0, 0); step();
    issue(0, 0, 32'h100, 8'h0, 64'h0, 0, 64'hDEADBEAA); step();
    repeat (6) step();
    issue(0, 0, 32'h100, 8'h0, 64'h0, 0, 64'hDEADBEAA); step();
    issue(0, 0, 32'h100, 8'h0, 64'h0, 0, 64'hDEADBEAA); step();
    issue(0, 0, 32'h100, 8'h0, 64'h0, 0, 64'hDEADBEAA); step();
    rst_ni = 1'b0;
    q[0].delete();
    repeat (3) step();
    rst_ni = 1'b1;
    repeat (8) step();
    issue(0, 0, 32'h100, 8'h0, 64'h0, 0, 64'hDEADBEAA); step();
    issue(0, 1, 32'h40, 8'hF, 64'h12345678, 0, 0); step();
    issue(0, 0, 32'h40, 8'h0, 64'h0, 0, 64'h12345678); step();
    issue(0, 1, 32'h0, 8'hF, 64'hCAFEF00D, 0, 0); step();
`ifdef SOC_MEM_CTRL_ERR_EN
    issue(0, 0, 32'h0001_0000, 8'h0, 64'h0, 1, 0); step();
    issue(0, 1, 32'h0001_0000, 8'hF, 64'hFFFFFFFF, 1, 0); step();
    issue(0, 0, 32'h0, 8'h0, 64'h0, 0, 64'hCAFEF00D); step();
`else
    issue(0, 0, 32'h0001_0000, 8'h0, 64'h0, 0, 64'hCAFEF00D); step();
    issue(0, 1, 32'h0001_0000, 8'hF, 64'h0BADBEEF, 0, 0); step();
    issue(0, 0, 32'h0, 8'h0, 64'h0, 0, 64'h0BADBEEF); step();
`endif
    for (int k = 0; k < 8; k++) begin
      issue(1, 1, 32'(4 * k), 8'hF, 64'(k + 1), 0, 0); step();
    end
    for (int k = 0; k < 8; k++) begin
      issue(1, 0, 32'(4 * k), 8'h0, 64'h0, 0, 64'(k + 1)); step();
    end
    issue(2, 1, 32'h8, 8'hFF, 64'h1122334455667788, 0, 0); step();
    issue(2, 1, 32'h8, 8'h00, 64'h0, 0, 0); step();
    issue(2, 0, 32'h8, 8'h00, 64'h0, 0, 64'h1122334455667788); step();
    issue(2, 0, 32'hC, 8'h00, 64'h0, 0, 64'h1122334455667788); step();
    issue(2, 1, 32'h10, 8'hFF, 64'h0, 0, 0); step();
    issue(2, 1, 32'h10, 8'hF0, 64'hAAAAAAAA_BBBBBBBB, 0, 0); step();
    issue(2, 0, 32'h10, 8'h00, 64'h0, 0, 64'hAAAAAAAA_00000000); step();
    repeat (8) step();
    chk("drain_a", 64'(q[0].size()), 64'(0));
    chk("drain_b", 64'(q[1].size()), 64'(0));
    chk("drain_c", 64'(q[2].size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
